// File: rtl/pfx_scan.sv
// pfx_scan: Blelloch (up-sweep / down-sweep) prefix scan over a V_LEN vector,
// exclusive or inclusive per vector, with widened results, total and overflow.
module pfx_scan #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 8,
  parameter int V_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inclusive,
  input  logic [V_LEN*IWIDTH-1:0] ivec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [V_LEN*OWIDTH-1:0] ovec,
  output logic [OWIDTH-1:0]       total,
  output logic                    ovf
);
  localparam int L    = $clog2(V_LEN);
  localparam int LVLW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {IDLE, UP, CLEAR, DOWN, FIX, OUT} state_t;

  state_t            state_q, state_d;
  logic [LVLW-1:0]   level_q, level_d;
  logic [OWIDTH-1:0] x_q    [V_LEN];
  logic [OWIDTH-1:0] x_d    [V_LEN];
  logic [IWIDTH-1:0] orig_q [V_LEN];
  logic [IWIDTH-1:0] orig_d [V_LEN];
  logic [OWIDTH-1:0] ovec_q [V_LEN];
  logic [OWIDTH-1:0] ovec_d [V_LEN];
  logic [OWIDTH-1:0] total_q, total_d;
  logic              incl_q, incl_d;
  logic              acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [L-1:0]      lo_c, hi_c;
  logic [OWIDTH:0]   sum_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      total_q     <= '0;
      incl_q      <= 1'b0;
      acc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int k = 0; k < V_LEN; k++) begin
        x_q[k]    <= '0;
        orig_q[k] <= '0;
        ovec_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      total_q     <= total_d;
      incl_q      <= incl_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      orig_q      <= orig_d;
      ovec_q      <= ovec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    total_d     = total_q;
    incl_d      = incl_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    orig_d      = orig_q;
    ovec_d      = ovec_q;
    lo_c        = '0;
    hi_c        = '0;
    sum_c       = '0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int k = 0; k < V_LEN; k++) begin
            x_d[k]    = OWIDTH'(ivec[k*IWIDTH +: IWIDTH]);
            orig_d[k] = ivec[k*IWIDTH +: IWIDTH];
          end
          incl_d     = in_inclusive;
          acc_d      = 1'b0;
          level_d    = '0;
          in_ready_d = 1'b0;
          state_d    = UP;
        end
      end
      UP: begin
        // Any partial-sum carry implies the true total overflows, and vice versa.
        for (int d = 0; d < L; d++) begin
          if (level_q == LVLW'(d)) begin
            for (int p = 0; p < (V_LEN >> (d + 1)); p++) begin
              lo_c  = L'(p * (2 << d) + (1 << d) - 1);
              hi_c  = L'(p * (2 << d) + (2 << d) - 1);
              sum_c = {1'b0, x_q[lo_c]} + {1'b0, x_q[hi_c]};
              x_d[hi_c] = sum_c[OWIDTH-1:0];
              acc_d     = acc_d | sum_c[OWIDTH];
            end
          end
        end
        if (level_q == LVLW'(L - 1)) state_d = CLEAR;
        else                         level_d = level_q + 1'b1;
      end
      CLEAR: begin
        total_d        = x_q[V_LEN-1];
        x_d[V_LEN-1]   = '0;
        ovf_d          = acc_q;
        level_d        = LVLW'(L - 1);
        state_d        = DOWN;
      end
      DOWN: begin
        for (int d = 0; d < L; d++) begin
          if (level_q == LVLW'(d)) begin
            for (int p = 0; p < (V_LEN >> (d + 1)); p++) begin
              lo_c      = L'(p * (2 << d) + (1 << d) - 1);
              hi_c      = L'(p * (2 << d) + (2 << d) - 1);
              x_d[lo_c] = x_q[hi_c];
              x_d[hi_c] = x_q[lo_c] + x_q[hi_c];
            end
          end
        end
        if (level_q == '0) state_d = FIX;
        else               level_d = level_q - 1'b1;
      end
      FIX: begin
        for (int k = 0; k < V_LEN; k++)
          ovec_d[k] = x_q[k] + (incl_q ? OWIDTH'(orig_q[k]) : '0);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < V_LEN; gi++) begin : g_pack
    assign ovec[gi*OWIDTH +: OWIDTH] = ovec_q[gi];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign total     = total_q;
  assign ovf       = ovf_q;
endmodule
